// File: rtl/aes_block_fetch.sv
// Read sequencer for aes_ram: fetches 4-word blocks through the RAM's registered
// read port and presents each one on a valid/ready stream to the datapath.
module aes_block_fetch #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int RAM_DEPTH = 44,
  parameter int CNT_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    num_blks,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [4*DATA_W-1:0] blk_data,
  output logic [CNT_W-1:0]    blk_idx,
  output logic                blk_valid,
  input  logic                blk_ready
);

  localparam int EXT_W = ADDR_W + 3;

  typedef enum logic [2:0] {IDLE, FETCH, LAST, OUT, FIN} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   base_reg, base_next;
  logic [CNT_W-1:0]    num_reg, num_next;
  logic [CNT_W-1:0]    idx_reg, idx_next;
  logic [1:0]          w_reg, w_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   buf_reg [3];
  logic [DATA_W-1:0]   buf_next [3];
  logic [4*DATA_W-1:0] data_reg, data_next;
  logic                valid_reg, valid_next;
  logic                err_reg, err_next;

  logic [EXT_W-1:0]    end_addr;
  logic                req_bad;
  logic [CNT_W-1:0]    idx_inc;
  logic [ADDR_W-1:0]   next_blk_addr;
  logic [4*DATA_W-1:0] blk_words_cat;

  // Range check is done wide enough that base + 4*num can never wrap.
  assign end_addr      = EXT_W'(base_addr) + EXT_W'({num_blks, 2'b00});
  assign req_bad       = (num_blks == '0) || (end_addr > EXT_W'(RAM_DEPTH));
  assign idx_inc       = idx_reg + CNT_W'(1);
  assign next_blk_addr = base_reg + ADDR_W'({idx_inc, 2'b00});

  // Words 0..2 come from the staging buffer, word 3 straight off the RAM port.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pack
      if (gi < 3) begin : g_buf
        assign blk_words_cat[(3-gi)*DATA_W +: DATA_W] = buf_reg[gi];
      end else begin : g_ram
        assign blk_words_cat[(3-gi)*DATA_W +: DATA_W] = ram_rdata;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    base_next  = base_reg;
    num_next   = num_reg;
    idx_next   = idx_reg;
    w_next     = w_reg;
    addr_next  = addr_reg;
    buf_next   = buf_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          base_next = base_addr;
          num_next  = num_blks;
          err_next  = req_bad;
          if (req_bad) begin
            state_next = FIN;
          end else begin
            idx_next   = '0;
            w_next     = 2'd0;
            addr_next  = base_addr;
            state_next = FETCH;
          end
        end
      end
      FETCH: begin
        // Data on the port belongs to the address presented one cycle earlier.
        if (w_reg != 2'd0) buf_next[w_reg - 2'd1] = ram_rdata;
        if (w_reg == 2'd3) begin
          state_next = LAST;
        end else begin
          w_next    = w_reg + 2'd1;
          addr_next = addr_reg + ADDR_W'(1);
        end
      end
      LAST: begin
        data_next  = blk_words_cat;
        valid_next = 1'b1;
        state_next = OUT;
      end
      OUT: begin
        if (blk_ready) begin
          valid_next = 1'b0;
          if (idx_inc < num_reg) begin
            idx_next   = idx_inc;
            w_next     = 2'd0;
            addr_next  = next_blk_addr;
            state_next = FETCH;
          end else begin
            state_next = FIN;
          end
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_reg  <= '0;
      num_reg   <= '0;
      idx_reg   <= '0;
      w_reg     <= '0;
      addr_reg  <= '0;
      for (int i = 0; i < 3; i++) buf_reg[i] <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      base_reg  <= base_next;
      num_reg   <= num_next;
      idx_reg   <= idx_next;
      w_reg     <= w_next;
      addr_reg  <= addr_next;
      buf_reg   <= buf_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == FIN);
  assign err       = err_reg;
  assign ram_we    = 1'b0;
  assign ram_addr  = addr_reg;
  assign blk_data  = data_reg;
  assign blk_idx   = idx_reg;
  assign blk_valid = valid_reg;

endmodule
